// File: rtl/change_dispenser.sv
// change_dispenser: pays back (total - PRICE) as 3/2/1-unit coins over a valid/ack handshake.
// Optional CHANGE_TIMEOUT_EN: abort a coin after ACK_TIMEOUT cycles without coin_ack.
`default_nettype none

module change_dispenser #(
  parameter int PRICE       = 4,
  parameter int INIT_CNT1   = 4,
  parameter int INIT_CNT2   = 4,
  parameter int INIT_CNT3   = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] total,
  input  logic       refill,
  input  logic       coin_ack,
  output logic [1:0] coin_out,
  output logic       coin_valid,
  output logic       busy,
  output logic       done,
  output logic       refund,
  output logic       short,
  output logic [3:0] short_amt
);

  localparam logic [3:0] PRICE_V = 4'(PRICE);
  localparam logic [3:0] INIT1_V = 4'(INIT_CNT1);
  localparam logic [3:0] INIT2_V = 4'(INIT_CNT2);
  localparam logic [3:0] INIT3_V = 4'(INIT_CNT3);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SELECT   = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] remaining;
  logic [3:0] inv1, inv2, inv3;
  logic [1:0] pick;

`ifdef CHANGE_TIMEOUT_EN
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] timer;
`endif

  // Greedy choice: largest denomination that fits and is still in stock.
  always_comb begin
    pick = 2'd0;
    if (remaining >= 4'd3 && inv3 != 4'd0)
      pick = 2'd3;
    else if (remaining >= 4'd2 && inv2 != 4'd0)
      pick = 2'd2;
    else if (remaining >= 4'd1 && inv1 != 4'd0)
      pick = 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      remaining  <= 4'd0;
      inv1       <= INIT1_V;
      inv2       <= INIT2_V;
      inv3       <= INIT3_V;
      coin_out   <= 2'd0;
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      refund     <= 1'b0;
      short      <= 1'b0;
      short_amt  <= 4'd0;
`ifdef CHANGE_TIMEOUT_EN
      timer      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (refill) begin
            inv1 <= INIT1_V;
            inv2 <= INIT2_V;
            inv3 <= INIT3_V;
          end
          if (start) begin
            busy      <= 1'b1;
            short     <= 1'b0;
            short_amt <= 4'd0;
            if (total >= PRICE_V) begin
              remaining <= total - PRICE_V;
              refund    <= 1'b0;
            end else begin
              remaining <= total;
              refund    <= 1'b1;
            end
            state <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (remaining == 4'd0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (pick != 2'd0) begin
            coin_out   <= pick;
            coin_valid <= 1'b1;
`ifdef CHANGE_TIMEOUT_EN
            timer      <= '0;
`endif
            state      <= S_WAIT_ACK;
          end else begin
            short     <= 1'b1;
            short_amt <= remaining;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_WAIT_ACK: begin
          if (coin_ack) begin
            remaining <= remaining - {2'b00, coin_out};
            case (coin_out)
              2'd1:    if (inv1 != 4'd0) inv1 <= inv1 - 4'd1;
              2'd2:    if (inv2 != 4'd0) inv2 <= inv2 - 4'd1;
              2'd3:    if (inv3 != 4'd0) inv3 <= inv3 - 4'd1;
              default: ;
            endcase
            coin_out   <= 2'd0;
            coin_valid <= 1'b0;
            state      <= S_SELECT;
`ifdef CHANGE_TIMEOUT_EN
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            // Abandoned coin is not counted; the whole remainder is reported short.
            coin_out   <= 2'd0;
            coin_valid <= 1'b0;
            short      <= 1'b1;
            short_amt  <= remaining;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
`endif
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
